// File: rtl/valet_arrival_queue_if.sv
// Gate / valet-FSM handshake bundle for valet_arrival_queue.
// Optional statistics signals exist only when ARRIVAL_STATS_EN is defined.
interface valet_arrival_queue_if #(
  parameter int DEPTH    = 8,
  parameter int PLATE_W  = 16,
  parameter int TICKET_W = 8
);
  localparam int INFO_W = TICKET_W + 1 + PLATE_W;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic                gate_valid;
  logic [PLATE_W-1:0]  gate_plate;
  logic                gate_vip;
  logic                gate_ready;
  logic                issued_valid;
  logic [TICKET_W-1:0] issued_ticket;
  logic                arrival_valid;
  logic [INFO_W-1:0]   arrival_info;
  logic                arrival_ready;
  logic                flush;
  logic [CNT_W-1:0]    queue_count;
`ifdef ARRIVAL_STATS_EN
  logic [15:0]         reject_count;
  logic [CNT_W-1:0]    peak_count;
`endif

  // Queue side
  modport slave (
    input  gate_valid, gate_plate, gate_vip, arrival_ready, flush,
    output gate_ready, issued_valid, issued_ticket, arrival_valid, arrival_info,
`ifdef ARRIVAL_STATS_EN
    output reject_count, peak_count,
`endif
    output queue_count
  );

  // Gate / valet-FSM side
  modport master (
    output gate_valid, gate_plate, gate_vip, arrival_ready, flush,
    input  gate_ready, issued_valid, issued_ticket, arrival_valid, arrival_info,
`ifdef ARRIVAL_STATS_EN
    input  reject_count, peak_count,
`endif
    input  queue_count
  );
endinterface

// File: rtl/valet_arrival_queue.sv
// FIFO ingress buffer that tickets arriving cars and hands them to the valet FSM.
// Define ARRIVAL_STATS_EN to add reject_count / peak_count statistics.
module valet_arrival_queue #(
  parameter int DEPTH    = 8,
  parameter int PLATE_W  = 16,
  parameter int TICKET_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  valet_arrival_queue_if.slave  bus
);
  localparam int INFO_W = TICKET_W + 1 + PLATE_W;
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0]    PTR_LAST   = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]    CNT_FULL   = CNT_W'(DEPTH);
  localparam logic [TICKET_W-1:0] TICKET_MAX = '1;

  logic [INFO_W-1:0]   mem [DEPTH];

  logic [PTR_W-1:0]    rd_ptr_reg, rd_ptr_next;
  logic [PTR_W-1:0]    wr_ptr_reg, wr_ptr_next;
  logic [CNT_W-1:0]    count_reg, count_next;
  logic [TICKET_W-1:0] next_ticket_reg, next_ticket_next;
  logic                issued_valid_reg, issued_valid_next;
  logic [TICKET_W-1:0] issued_ticket_reg, issued_ticket_next;

  logic gate_ready;
  logic arrival_valid;
  logic accept;
  logic pop;

  // Readiness comes from registered occupancy only; flush blocks the gate outright.
  assign gate_ready    = (count_reg != CNT_FULL) && !bus.flush;
  assign arrival_valid = (count_reg != '0);
  assign accept        = bus.gate_valid && gate_ready;
  assign pop           = arrival_valid && bus.arrival_ready && !bus.flush;

  always_comb begin
    rd_ptr_next        = rd_ptr_reg;
    wr_ptr_next        = wr_ptr_reg;
    count_next         = count_reg;
    next_ticket_next   = next_ticket_reg;
    issued_valid_next  = accept;
    issued_ticket_next = issued_ticket_reg;

    if (bus.flush) begin
      rd_ptr_next = '0;
      wr_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (accept) begin
        wr_ptr_next        = (wr_ptr_reg == PTR_LAST) ? '0 : wr_ptr_reg + PTR_W'(1);
        // Ticket 0 means "no ticket", so the counter wraps to 1.
        next_ticket_next   = (next_ticket_reg == TICKET_MAX) ? TICKET_W'(1)
                                                             : next_ticket_reg + TICKET_W'(1);
        issued_ticket_next = next_ticket_reg;
      end
      if (pop) begin
        rd_ptr_next = (rd_ptr_reg == PTR_LAST) ? '0 : rd_ptr_reg + PTR_W'(1);
      end
      case ({accept, pop})
        2'b10:   count_next = count_reg + CNT_W'(1);
        2'b01:   count_next = count_reg - CNT_W'(1);
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_reg        <= '0;
      wr_ptr_reg        <= '0;
      count_reg         <= '0;
      next_ticket_reg   <= TICKET_W'(1);
      issued_valid_reg  <= 1'b0;
      issued_ticket_reg <= '0;
    end else begin
      rd_ptr_reg        <= rd_ptr_next;
      wr_ptr_reg        <= wr_ptr_next;
      count_reg         <= count_next;
      next_ticket_reg   <= next_ticket_next;
      issued_valid_reg  <= issued_valid_next;
      issued_ticket_reg <= issued_ticket_next;
    end
  end

  // Storage carries no reset; entries beyond count are never presented.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr_reg] <= {next_ticket_reg, bus.gate_vip, bus.gate_plate};
    end
  end

  assign bus.gate_ready    = gate_ready;
  assign bus.arrival_valid = arrival_valid;
  assign bus.arrival_info  = arrival_valid ? mem[rd_ptr_reg] : '0;
  assign bus.issued_valid  = issued_valid_reg;
  assign bus.issued_ticket = issued_ticket_reg;
  assign bus.queue_count   = count_reg;

`ifdef ARRIVAL_STATS_EN
  logic [15:0]      reject_count_reg;
  logic [CNT_W-1:0] peak_count_reg;

  // Peak follows the upcoming occupancy so it never trails queue_count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      reject_count_reg <= '0;
      peak_count_reg   <= '0;
    end else begin
      if (bus.gate_valid && !gate_ready && (reject_count_reg != 16'hFFFF)) begin
        reject_count_reg <= reject_count_reg + 16'd1;
      end
      if (count_next > peak_count_reg) begin
        peak_count_reg <= count_next;
      end
    end
  end

  assign bus.reject_count = reject_count_reg;
  assign bus.peak_count   = peak_count_reg;
`endif
endmodule
